// File: rtl/sipo_pkg.sv
// Shared types and constants for the sipo_deser serial-in parallel-out receiver.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 4;

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } sipo_state_e;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int sipo_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for one data frame, MSB first.
// Flags the edge that samples the last data bit of the frame.
import sipo_pkg::*;

module sipo_shift_core #(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_word,
    output logic             o_busy,
    output logic             o_frame_done
);

    localparam int CW = sipo_cnt_w(WIDTH);

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            r_shreg <= {r_shreg[WIDTH-2:0], i_sin};
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Word as it stands after this edge, so a load on the final edge includes the bit being sampled.
    assign o_word       = i_shift_en ? {r_shreg[WIDTH-2:0], i_sin} : r_shreg;
    assign o_busy       = (r_cnt != '0);
    assign o_frame_done = i_shift_en && w_last;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words and offers them on a valid/ready holding register.
// Optional even-parity bit per frame when SIPO_PARITY_EN is defined.
import sipo_pkg::*;

module sipo_deser #(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_en,
    input  logic             sin,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    // Handshake: pout is held stable while pout_valid=1; a word is consumed on any rising edge
    // with pout_valid && pout_ready. pout_ready is ignored while pout_valid=0.

    logic [WIDTH-1:0] r_pout;
    logic             r_valid;
    logic             r_overrun;
    logic [WIDTH-1:0] w_word;
    logic             w_core_busy;
    logic             w_data_done;
    logic             w_shift_en;
    logic             w_frame_done;
    logic             w_free;
    logic             w_load;

`ifdef SIPO_PARITY_EN
    sipo_state_e r_state;
    logic        r_perr;

    assign w_shift_en   = sin_en && (r_state == ST_DATA);
    assign w_frame_done = sin_en && (r_state == ST_PAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DATA;
        end else if (w_data_done) begin
            r_state <= ST_PAR;
        end else if (w_frame_done) begin
            r_state <= ST_DATA;
        end
    end

    // Dropped frames leave the reported parity of the held word untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= ^{w_word, sin};
        end
    end

    assign parity_err = r_perr;
    assign busy       = w_core_busy || (r_state == ST_PAR);
`else
    assign w_shift_en   = sin_en;
    assign w_frame_done = w_data_done;
    assign busy         = w_core_busy;
`endif

    sipo_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_shift_en  (w_shift_en),
        .i_sin       (sin),
        .o_word      (w_word),
        .o_busy      (w_core_busy),
        .o_frame_done(w_data_done)
    );

    assign w_free = !r_valid || pout_ready;
    assign w_load = w_frame_done && w_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                if (w_free) begin
                    r_pout  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && pout_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pout       = r_pout;
    assign pout_valid = r_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus randomized traffic against a frame-level model.
// Honours SIPO_PARITY_EN the same way as the design.
module tb_sipo_deser;

    localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic             sin_en;
    logic             sin;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level view of the link
    int   m_bits;
    int   m_acc;
    int   m_pbit;
    int   m_pout;
    logic m_valid;
    logic m_overrun;
    logic m_perr;

    sipo_deser #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_en    (sin_en),
        .sin       (sin),
        .pout      (pout),
        .pout_valid(pout_valid),
        .pout_ready(pout_ready),
        .busy      (busy),
`ifdef SIPO_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge(input logic en, input logic b, input logic rdy, input logic r);
        logic complete;
        complete = 1'b0;
        if (r) begin
            m_bits = 0; m_acc = 0; m_pbit = 0; m_pout = 0;
            m_valid = 1'b0; m_overrun = 1'b0; m_perr = 1'b0;
            return;
        end
        m_overrun = 1'b0;
        if (en) begin
            m_bits = m_bits + 1;
            if (m_bits <= WIDTH) m_acc = (m_acc * 2 + int'(b)) % (1 << WIDTH);
            else m_pbit = int'(b);
            if (m_bits == FL) begin
                complete = 1'b1;
                m_bits = 0;
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_pout  = m_acc;
                m_valid = 1'b1;
                m_perr  = (^m_acc[WIDTH-1:0]) ^ m_pbit[0];
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic step(input logic en, input logic b, input logic rdy, input logic r);
        sin_en = en; sin = b; pout_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(en, b, rdy, r);
        #1;
    endtask

    // Sends one full frame back to back; pout_ready is raised only on the final edge if asked.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last, input logic bad_par);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], (FL == WIDTH && i == 0) ? rdy_last : 1'b0, 1'b0);
        end
        if (FL != WIDTH) step(1'b1, (^w) ^ bad_par, rdy_last, 1'b0);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) step(1'b1, i[0], 1'b0, 1'b1);
        n_checks++;
        if ({pout, pout_valid, busy, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pout=%b valid=%b busy=%b ovr=%b, want all 0", pout, pout_valid, busy, overrun);
        end
`ifdef SIPO_PARITY_EN
        n_checks++;
        if (parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_parity_err: got %b want 0", parity_err);
        end
`endif
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] w;
        w = 4'b1011;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_word(w, 1'b0, 1'b0);
        n_checks++;
        if (pout !== w || pout_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word: got pout=%b valid=%b busy=%b, want %b/1/0", pout, pout_valid, busy, w);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pout_valid !== 1'b0 || pout !== w) begin
            n_fail++;
            $display("FAIL basic_accept: got valid=%b pout=%b, want 0/%b", pout_valid, pout, w);
        end
    endtask

    task automatic test_gapped;
        logic [WIDTH-1:0] w;
        w = 4'b0110;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0, 1'b0);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, ~w[i], 1'b0, 1'b0);
                    n_checks++;
                    if (busy !== 1'b1 || pout_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL gapped_busy: bit %0d gap %0d got busy=%b valid=%b, want 1/0", i, g, busy, pout_valid);
                    end
                end
            end
        end
        if (FL != WIDTH) step(1'b1, ^w, 1'b0, 1'b0);
        n_checks++;
        if (pout !== w || pout_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gapped_word: got pout=%b valid=%b busy=%b, want %b/1/0", pout, pout_valid, busy, w);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun;
        send_word(4'b1011, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0 || pout !== 4'b1011) begin
            n_fail++;
            $display("FAIL ovr_first: got ovr=%b pout=%b, want 0/1011", overrun, pout);
        end
        send_word(4'b0101, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b1 || pout !== 4'b1011 || pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got ovr=%b pout=%b valid=%b, want 1/1011/1", overrun, pout, pout_valid);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0 || pout !== 4'b1011) begin
            n_fail++;
            $display("FAIL ovr_one_cycle: got ovr=%b pout=%b, want 0/1011", overrun, pout);
        end
        send_word(4'b1100, 1'b1, 1'b0);
        n_checks++;
        if (pout !== 4'b1100 || pout_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_accept_load: got pout=%b valid=%b ovr=%b, want 1100/1/0", pout, pout_valid, overrun);
        end
    endtask

    task automatic test_mid_reset;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || pout_valid !== 1'b0 || pout !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got busy=%b valid=%b pout=%b, want 0/0/0000", busy, pout_valid, pout);
        end
        send_word(4'b0011, 1'b0, 1'b0);
        n_checks++;
        if (pout !== 4'b0011 || pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_word: got pout=%b valid=%b, want 0011/1", pout, pout_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity;
        send_word(4'b1011, 1'b1, 1'b0);
        n_checks++;
        if (parity_err !== 1'b0 || pout !== 4'b1011 || pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_good: got perr=%b pout=%b valid=%b, want 0/1011/1", parity_err, pout, pout_valid);
        end
        send_word(4'b1011, 1'b1, 1'b1);
        n_checks++;
        if (parity_err !== 1'b1 || pout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: got perr=%b valid=%b, want 1/1", parity_err, pout_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random;
        logic en, b, rdy, r;
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step(en, b, rdy, r);
            n_checks++;
            if (pout !== WIDTH'(m_pout) || pout_valid !== m_valid || busy !== (m_bits != 0) || overrun !== m_overrun) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got pout=%b valid=%b busy=%b ovr=%b, want %b/%b/%b/%b",
                         c, pout, pout_valid, busy, overrun, WIDTH'(m_pout), m_valid, (m_bits != 0), m_overrun);
            end
`ifdef SIPO_PARITY_EN
            if (m_valid) begin
                n_checks++;
                if (parity_err !== m_perr) begin
                    n_fail++;
                    $display("FAIL random_parity %0d: got %b want %b", c, parity_err, m_perr);
                end
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; sin_en = 1'b0; sin = 1'b0; pout_ready = 1'b0;
        model_edge(1'b0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_mid_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
